// File: rtl/rf_feature_sampler.sv
// Refresh-predictor feature sampler: counts six event strobes per window, hands the scaled
// fractions to the decision-tree walker and applies its tREFI prediction. Optional macro: RF_TREFI_HYST_EN.
module rf_feature_sampler #(
   parameter int         WIN_LOG2      = 10,
   parameter int         TIMEOUT       = 64,
   parameter logic [7:0] DEFAULT_TREFI = 8'd32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       req_evt,
   input  logic       load_evt,
   input  logic       miss_evt,
   input  logic       risk_evt,
   input  logic       rbhit_evt,
   input  logic       rbconf_evt,
   output logic [7:0] req_per_cycle,
   output logic [7:0] conflict_load,
   output logic [7:0] llc_miss,
   output logic [7:0] traffic_risk,
   output logic [7:0] rb_locality,
   output logic [7:0] rb_conflict,
   output logic       start,
   input  logic       done,
   input  logic [7:0] t_refi,
   output logic [7:0] t_refi_out,
   output logic       trefi_update,
   output logic       timeout_err,
   output logic [7:0] overrun_cnt
);

   localparam int CW    = WIN_LOG2 + 1;
   localparam int SHIFT = WIN_LOG2 - 8;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

   logic [5:0]          evt;
   logic [WIN_LOG2-1:0] win_cnt;
   logic                win_end;
   logic [CW-1:0]       cnt    [6];
   logic [CW-1:0]       snap   [6];
   logic [CW-1:0]       scaled [6];
   logic [7:0]          feat_d [6];
   logic [7:0]          feat_q [6];
   state_t              state_q, state_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic                capture, tmo, load_feat;
   logic [7:0]          cap_q;
   logic                cap_vld_q;
   logic                apply;

   assign evt     = {rbconf_evt, rbhit_evt, risk_evt, miss_evt, load_evt, req_evt};
   assign win_end = enable && (win_cnt == '1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt <= '0;
         for (int i = 0; i < 6; i++) cnt[i] <= '0;
      end else if (!enable) begin
         win_cnt <= '0;
         for (int i = 0; i < 6; i++) cnt[i] <= '0;
      end else begin
         win_cnt <= win_cnt + WIN_LOG2'(1);
         for (int i = 0; i < 6; i++) cnt[i] <= win_end ? '0 : cnt[i] + CW'(evt[i]);
      end
   end

   // The last cycle's strobe is folded into the snapshot; a full window saturates to 255.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         snap[i]   = cnt[i] + CW'(evt[i]);
         scaled[i] = snap[i] >> SHIFT;
         feat_d[i] = (scaled[i] > CW'(255)) ? 8'hFF : scaled[i][7:0];
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      start     = 1'b0;
      capture   = 1'b0;
      tmo       = 1'b0;
      load_feat = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_end) begin
               load_feat = 1'b1;
               tmr_d     = '0;
               state_d   = REQ;
            end
         end
         REQ: begin
            start = 1'b1;
            if (done) begin
               capture = 1'b1;
               state_d = ACK;
            end else if (tmr_q == TMR_LAST) begin
               tmo     = 1'b1;
               state_d = ACK;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         ACK: begin
            if (!done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) feat_q[i] <= '0;
      end else if (load_feat) begin
         for (int i = 0; i < 6; i++) feat_q[i] <= feat_d[i];
      end
   end

   assign req_per_cycle = feat_q[0];
   assign conflict_load = feat_q[1];
   assign llc_miss      = feat_q[2];
   assign traffic_risk  = feat_q[3];
   assign rb_locality   = feat_q[4];
   assign rb_conflict   = feat_q[5];

`ifdef RF_TREFI_HYST_EN
   logic [7:0] hist_q;
   logic       hist_vld_q;

   // A new value needs two consecutive identical predictions; a timeout breaks the streak.
   always_comb begin
      apply = cap_vld_q && (cap_q != t_refi_out) && hist_vld_q && (cap_q == hist_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q     <= '0;
         hist_vld_q <= 1'b0;
      end else if (tmo) begin
         hist_vld_q <= 1'b0;
      end else if (cap_vld_q) begin
         hist_q     <= cap_q;
         hist_vld_q <= 1'b1;
      end
   end
`else
   assign apply = cap_vld_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_q        <= '0;
         cap_vld_q    <= 1'b0;
         t_refi_out   <= DEFAULT_TREFI;
         trefi_update <= 1'b0;
         timeout_err  <= 1'b0;
         overrun_cnt  <= '0;
      end else begin
         cap_vld_q    <= capture;
         trefi_update <= apply;
         if (capture) cap_q <= t_refi;
         if (apply) t_refi_out <= cap_q;
         if (tmo) timeout_err <= 1'b1;
         if (win_end && (state_q != IDLE) && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_rf_feature_sampler.sv
// Directed bench for rf_feature_sampler (WIN_LOG2=10, TIMEOUT=64, default build) with a walker model.
module tb_rf_feature_sampler;

   localparam int NW = 1024;

   logic       clk, rst, enable;
   logic       req_evt, load_evt, miss_evt, risk_evt, rbhit_evt, rbconf_evt;
   logic [7:0] req_per_cycle, conflict_load, llc_miss, traffic_risk, rb_locality, rb_conflict;
   logic       start, done, trefi_update, timeout_err;
   logic [7:0] t_refi, t_refi_out, overrun_cnt;

   rf_feature_sampler #(.WIN_LOG2(10), .TIMEOUT(64), .DEFAULT_TREFI(8'd32)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req_evt(req_evt), .load_evt(load_evt), .miss_evt(miss_evt),
      .risk_evt(risk_evt), .rbhit_evt(rbhit_evt), .rbconf_evt(rbconf_evt),
      .req_per_cycle(req_per_cycle), .conflict_load(conflict_load), .llc_miss(llc_miss),
      .traffic_risk(traffic_risk), .rb_locality(rb_locality), .rb_conflict(rb_conflict),
      .start(start), .done(done), .t_refi(t_refi), .t_refi_out(t_refi_out),
      .trefi_update(trefi_update), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Walker model: done three cycles after start, held until start falls plus an optional stretch.
   logic [7:0] pred_m;
   bit         never_m;
   int         stretch_m;
   int         scnt, hold;

   always @(negedge clk) begin
      if (rst) begin
         done = 1'b0; t_refi = 8'd0; scnt = 0; hold = 0;
      end else if (!done) begin
         if (start && !never_m) begin
            scnt++;
            if (scnt >= 3) begin
               done = 1'b1; t_refi = pred_m; hold = stretch_m;
            end
         end else begin
            scnt = 0;
         end
      end else if (!start) begin
         if (hold > 0) hold--;
         else begin
            done = 1'b0; scnt = 0;
         end
      end
   end

   int pulse_total = 0;
   int start_rises = 0;
   int run_len = 0;
   int last_run = 0;
   logic prev_start = 1'b0;

   always @(negedge clk) begin
      if (trefi_update === 1'b1) pulse_total++;
      if (start === 1'b1 && prev_start !== 1'b1) start_rises++;
      if (start === 1'b1) run_len++;
      else if (run_len != 0) begin
         last_run = run_len; run_len = 0;
      end
      prev_start = start;
   end

   typedef struct packed {
      logic [5:0][10:0] n;
      logic             tail;
      logic [7:0]       pred;
      logic             never;
      logic [10:0]      stretch;
      logic [5:0][7:0]  ef;
      logic             estart;
      logic [7:0]       etrefi;
      logic [1:0]       epulse;
      logic             eterr;
      logic [7:0]       eovr;
   } vec_t;

   function automatic vec_t mk(input int nr, nl, nm, nk, nh, nc, input bit tl,
                               input int pred, input bit nev, input int str,
                               input int f0, f1, f2, f3, f4, f5,
                               input bit es, input int et, input int ep, input bit eterr, input int eovr);
      vec_t v;
      v.n[0] = 11'(nr); v.n[1] = 11'(nl); v.n[2] = 11'(nm);
      v.n[3] = 11'(nk); v.n[4] = 11'(nh); v.n[5] = 11'(nc);
      v.tail = tl; v.pred = 8'(pred); v.never = nev; v.stretch = 11'(str);
      v.ef[0] = 8'(f0); v.ef[1] = 8'(f1); v.ef[2] = 8'(f2);
      v.ef[3] = 8'(f3); v.ef[4] = 8'(f4); v.ef[5] = 8'(f5);
      v.estart = es; v.etrefi = 8'(et); v.epulse = 2'(ep); v.eterr = eterr; v.eovr = 8'(eovr);
      return v;
   endfunction

   function automatic logic [7:0] get_feat(input int k);
      case (k)
         0: return req_per_cycle;
         1: return conflict_load;
         2: return llc_miss;
         3: return traffic_risk;
         4: return rb_locality;
         default: return rb_conflict;
      endcase
   endfunction

   task automatic set_evts(input logic [5:0] e);
      {rbconf_evt, rbhit_evt, risk_evt, miss_evt, load_evt, req_evt} = e;
   endtask

   // One full window; the walker behaviour for the handshake at this window's end is armed late in it.
   task automatic run_window(input vec_t v);
      for (int c = 0; c < NW; c++) begin
         logic [5:0] e;
         for (int k = 0; k < 6; k++)
            e[k] = v.tail ? (c >= NW - int'(v.n[k])) : (c < int'(v.n[k]));
         set_evts(e);
         if (c == 1000) begin
            pred_m = v.pred; never_m = v.never; stretch_m = int'(v.stretch);
         end
         @(negedge clk); #1;
      end
   endtask

   vec_t tv [11];

   initial begin
      int p0, r0;
      //          req  load miss risk rbhit rbconf tail pred nev str   features               start trefi pulse terr ovr
      tv[0]  = mk(1024, 0,   0,   0,    0,    0,  0,  40, 0,  0,   255,0,0,0,0,0,         1,  32, 0, 0, 0);
      tv[1]  = mk(0,    0, 160,   0,  988,    0,  0,  48, 0,  0,   0,0,40,0,247,0,        1,  40, 1, 0, 0);
      tv[2]  = mk(3,    4,   0,1023,    0,  513,  1,   0, 1,  0,   0,1,0,255,0,128,       1,  48, 1, 0, 0);
      tv[3]  = mk(100,  0,1024,   0,    0,    0,  0,  56, 0,  0,   25,0,255,0,0,0,        1,  48, 0, 1, 0);
      tv[4]  = mk(0,    0,   0,   0,  512,    0,  0,  60, 0,1100,  0,0,0,0,128,0,         1,  56, 1, 1, 0);
      tv[5]  = mk(1024, 0,   0,   0,    0,    0,  0,  70, 0,  0,   0,0,0,0,128,0,         0,  60, 1, 1, 1);
      tv[6]  = mk(0,    8,   0,   0,    0,    0,  0,  72, 0,  0,   0,2,0,0,0,0,           1,  60, 0, 1, 1);
      tv[7]  = mk(0,    0,   0,   0,    0, 1024,  0,  80, 0,  0,   0,0,0,0,0,255,         1,  72, 1, 1, 1);
      tv[8]  = mk(0,    0,   0,   0,    0,    0,  0,  90, 0,  0,   0,0,0,0,0,0,           1,  80, 0, 1, 1);
      tv[9]  = mk(1024, 0,   0,   0,    0,    0,  0,  44, 0,  0,   255,0,0,0,0,0,         1,  32, 0, 0, 0);
      tv[10] = mk(0,    0,   0,   0,    0,    0,  0,  44, 0,  0,   0,0,0,0,0,0,           1,  44, 1, 0, 0);

      rst = 1'b1; enable = 1'b1; set_evts(6'b0);
      pred_m = 8'd0; never_m = 1'b0; stretch_m = 0;
      repeat (3) @(negedge clk);
      #1;
      for (int k = 0; k < 6; k++) check($sformatf("reset_feat%0d", k), get_feat(k), 0);
      check("reset_start", start, 0);
      check("reset_trefi", t_refi_out, 32);
      check("reset_update", trefi_update, 0);
      check("reset_terr", timeout_err, 0);
      check("reset_ovr", overrun_cnt, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         if (i == 8) begin
            // Drop enable while a handshake is in flight: it finishes, no new window starts.
            r0 = start_rises;
            enable = 1'b0; set_evts(6'h3F);
            repeat (1100) @(negedge clk);
            #1;
            check("dis_no_new_start", start_rises, r0);
            check("dis_start_low", start, 0);
            check("dis_trefi_applied", t_refi_out, 80);
            check("dis_ovr", overrun_cnt, 1);
            set_evts(6'b0); enable = 1'b1;
         end
         if (i == 9) begin
            // Asynchronous reset while start is high.
            rst = 1'b1;
            #1;
            check("rst_start_drop", start, 0);
            check("rst_trefi", t_refi_out, 32);
            check("rst_terr", timeout_err, 0);
            check("rst_ovr", overrun_cnt, 0);
            repeat (2) @(negedge clk);
            #1;
            rst = 1'b0;
         end
         p0 = pulse_total;
         run_window(tv[i]);
         for (int k = 0; k < 6; k++)
            check($sformatf("w%0d_feat%0d", i, k), get_feat(k), tv[i].ef[k]);
         check($sformatf("w%0d_start", i), start, tv[i].estart);
         check($sformatf("w%0d_trefi", i), t_refi_out, tv[i].etrefi);
         check($sformatf("w%0d_pulses", i), pulse_total - p0, tv[i].epulse);
         check($sformatf("w%0d_terr", i), timeout_err, tv[i].eterr);
         check($sformatf("w%0d_ovr", i), overrun_cnt, tv[i].eovr);
         if (i == 3) check("timeout_start_len", last_run, 64);
      end

      // Same prediction again is still rewritten and pulses once.
      p0 = pulse_total;
      set_evts(6'b0);
      repeat (20) @(negedge clk);
      #1;
      check("rewrite_pulses", pulse_total - p0, 1);
      check("rewrite_trefi", t_refi_out, 44);
      check("rewrite_start_len", last_run, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
